// File: rtl/sprite_draw_sequencer_if.sv
// Sprite move requests in, single-pixel VGA write stream out.
interface sprite_draw_sequencer_if;
  logic       player_req;
  logic [7:0] player_x_in;
  logic [6:0] player_y_in;
  logic       cpu_req;
  logic [7:0] cpu_x_in;
  logic [6:0] cpu_y_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       player_done;
  logic       cpu_done;

  modport master (
    output player_req, player_x_in, player_y_in, cpu_req, cpu_x_in, cpu_y_in,
    input  x, y, colour, plot, busy, player_done, cpu_done
  );

  modport slave (
    input  player_req, player_x_in, player_y_in, cpu_req, cpu_x_in, cpu_y_in,
    output x, y, colour, plot, busy, player_done, cpu_done
  );
endinterface

// File: rtl/sprite_draw_sequencer.sv
// Serialises player/CPU sprite moves into erase-then-draw pixel writes for the VGA adapter.
//   state  | meaning
//   INIT_P | draw player at start position
//   INIT_C | draw CPU at start position
//   IDLE   | wait for a pending move, arbitrate
//   ERASE  | paint granted sprite's old position in background colour
//   DRAW   | paint granted sprite at its new position
//   DONE   | commit new position, pulse done
module sprite_draw_sequencer #(
  parameter int unsigned SPRITE_W      = 4,
  parameter int unsigned SPRITE_H      = 4,
  parameter int unsigned SCREEN_W      = 160,
  parameter int unsigned SCREEN_H      = 120,
  parameter logic [2:0]  PLAYER_COLOUR = 3'b100,
  parameter logic [2:0]  CPU_COLOUR    = 3'b001,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [7:0]  PLAYER_X0     = 8'd10,
  parameter logic [6:0]  PLAYER_Y0     = 7'd40,
  parameter logic [7:0]  CPU_X0        = 8'd10,
  parameter logic [6:0]  CPU_Y0        = 7'd80
) (
  input  logic                    clk,
  input  logic                    resetn,
  sprite_draw_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_INIT_P, S_INIT_C, S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  localparam logic       CH_P    = 1'b0;
  localparam logic       CH_C    = 1'b1;
  localparam logic [2:0] DX_LAST = 3'(SPRITE_W - 1);
  localparam logic [2:0] DY_LAST = 3'(SPRITE_H - 1);
  localparam logic [8:0] SCR_W   = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H   = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [2:0] dx_q, dx_d, dy_q, dy_d;
  logic       p_pend_q, p_pend_d, c_pend_q, c_pend_d;
  logic [7:0] p_nx_q, p_nx_d, c_nx_q, c_nx_d, p_ox_q, p_ox_d, c_ox_q, c_ox_d, cur_nx_q, cur_nx_d;
  logic [6:0] p_ny_q, p_ny_d, c_ny_q, c_ny_d, p_oy_q, p_oy_d, c_oy_q, c_oy_d, cur_ny_q, cur_ny_d;
  logic       chan_q, chan_d, last_q, last_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, p_done_q, p_done_d, c_done_q, c_done_d;

  logic [7:0] base_x, pix_x;
  logic [6:0] base_y, pix_y;
  logic [2:0] pix_col;
  logic       active, last_px, grant_c;

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    p_pend_d = p_pend_q;
    c_pend_d = c_pend_q;
    p_nx_d   = p_nx_q;
    p_ny_d   = p_ny_q;
    c_nx_d   = c_nx_q;
    c_ny_d   = c_ny_q;
    p_ox_d   = p_ox_q;
    p_oy_d   = p_oy_q;
    c_ox_d   = c_ox_q;
    c_oy_d   = c_oy_q;
    cur_nx_d = cur_nx_q;
    cur_ny_d = cur_ny_q;
    chan_d   = chan_q;
    last_d   = last_q;
    base_x   = 8'd0;
    base_y   = 7'd0;
    pix_col  = BG_COLOUR;
    active   = 1'b0;
    last_px  = (dx_q == DX_LAST) && (dy_q == DY_LAST);
    grant_c  = (p_pend_q && c_pend_q) ? ~last_q : c_pend_q;

    case (state_q)
      S_INIT_P: begin
        active  = 1'b1;
        base_x  = PLAYER_X0;
        base_y  = PLAYER_Y0;
        pix_col = PLAYER_COLOUR;
      end
      S_INIT_C: begin
        active  = 1'b1;
        base_x  = CPU_X0;
        base_y  = CPU_Y0;
        pix_col = CPU_COLOUR;
      end
      S_ERASE: begin
        active  = 1'b1;
        base_x  = (chan_q == CH_C) ? c_ox_q : p_ox_q;
        base_y  = (chan_q == CH_C) ? c_oy_q : p_oy_q;
        pix_col = BG_COLOUR;
      end
      S_DRAW: begin
        active  = 1'b1;
        base_x  = cur_nx_q;
        base_y  = cur_ny_q;
        pix_col = (chan_q == CH_C) ? CPU_COLOUR : PLAYER_COLOUR;
      end
      default: ;
    endcase

    pix_x = base_x + {5'd0, dx_q};
    pix_y = base_y + {4'd0, dy_q};

    if (active) begin
      if (dx_q == DX_LAST) begin
        dx_d = 3'd0;
        dy_d = last_px ? 3'd0 : dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end

    case (state_q)
      S_INIT_P: if (last_px) state_d = S_INIT_C;
      S_INIT_C: if (last_px) state_d = S_IDLE;
      S_ERASE:  if (last_px) state_d = S_DRAW;
      S_DRAW:   if (last_px) state_d = S_DONE;
      S_IDLE: begin
        if (p_pend_q || c_pend_q) begin
          // Snapshot the target so later requests can overwrite the latch mid-sequence.
          chan_d   = grant_c;
          last_d   = grant_c;
          cur_nx_d = grant_c ? c_nx_q : p_nx_q;
          cur_ny_d = grant_c ? c_ny_q : p_ny_q;
          if (grant_c) c_pend_d = 1'b0;
          else         p_pend_d = 1'b0;
          dx_d    = 3'd0;
          dy_d    = 3'd0;
          state_d = S_ERASE;
        end
      end
      S_DONE: begin
        if (chan_q == CH_C) begin
          c_ox_d = cur_nx_q;
          c_oy_d = cur_ny_q;
        end else begin
          p_ox_d = cur_nx_q;
          p_oy_d = cur_ny_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.player_req) begin
      p_pend_d = 1'b1;
      p_nx_d   = bus.player_x_in;
      p_ny_d   = bus.player_y_in;
    end
    if (bus.cpu_req) begin
      c_pend_d = 1'b1;
      c_nx_d   = bus.cpu_x_in;
      c_ny_d   = bus.cpu_y_in;
    end

    x_d      = active ? pix_x : x_q;
    y_d      = active ? pix_y : y_q;
    colour_d = active ? pix_col : colour_q;
    plot_d   = active && ({1'b0, pix_x} < SCR_W) && ({1'b0, pix_y} < SCR_H);
    p_done_d = (state_q == S_DONE) && (chan_q == CH_P);
    c_done_d = (state_q == S_DONE) && (chan_q == CH_C);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= S_INIT_P;
      dx_q     <= 3'd0;
      dy_q     <= 3'd0;
      p_pend_q <= 1'b0;
      c_pend_q <= 1'b0;
      p_nx_q   <= 8'd0;
      p_ny_q   <= 7'd0;
      c_nx_q   <= 8'd0;
      c_ny_q   <= 7'd0;
      p_ox_q   <= PLAYER_X0;
      p_oy_q   <= PLAYER_Y0;
      c_ox_q   <= CPU_X0;
      c_oy_q   <= CPU_Y0;
      cur_nx_q <= 8'd0;
      cur_ny_q <= 7'd0;
      chan_q   <= CH_P;
      last_q   <= CH_C;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b1;
      p_done_q <= 1'b0;
      c_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      p_pend_q <= p_pend_d;
      c_pend_q <= c_pend_d;
      p_nx_q   <= p_nx_d;
      p_ny_q   <= p_ny_d;
      c_nx_q   <= c_nx_d;
      c_ny_q   <= c_ny_d;
      p_ox_q   <= p_ox_d;
      p_oy_q   <= p_oy_d;
      c_ox_q   <= c_ox_d;
      c_oy_q   <= c_oy_d;
      cur_nx_q <= cur_nx_d;
      cur_ny_q <= cur_ny_d;
      chan_q   <= chan_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      p_done_q <= p_done_d;
      c_done_q <= c_done_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.colour      = colour_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = busy_q;
  assign bus.player_done = p_done_q;
  assign bus.cpu_done    = c_done_q;

endmodule

// File: doc/sprite_draw_sequencer.md
Name: sprite_draw_sequencer

Overview:
- Converts discrete sprite-move requests from the player and CPU racers into serialized single-pixel writes for the VGA adapter's x/y/colour/writeEn port.
- Each move erases the sprite at its previous position in the background colour, then draws it at the new position.
- Sits directly downstream of the player/CPU position logic and directly upstream of the VGA adapter.
- Replaces multi-edge output muxing with one synchronous, arbitrated write stream.

Parameters:
- SPRITE_W, 4, sprite width in pixels (1..8)
- SPRITE_H, 4, sprite height in pixels (1..8)
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed
- PLAYER_COLOUR, 3'b100, player sprite colour
- CPU_COLOUR, 3'b001, CPU sprite colour
- BG_COLOUR, 3'b000, erase colour
- PLAYER_X0 / PLAYER_Y0, 8'd10 / 7'd40, player start position
- CPU_X0 / CPU_Y0, 8'd10 / 7'd80, CPU start position

Ports:
- clk  input  1  system clock (50 MHz)
- resetn  input  1  synchronous reset, active-high (asserted = 1)
- player_req  input  1  one-cycle pulse: move player sprite
- player_x_in  input  8  new player top-left x, sampled with player_req
- player_y_in  input  7  new player top-left y, sampled with player_req
- cpu_req  input  1  one-cycle pulse: move CPU sprite
- cpu_x_in  input  8  new CPU top-left x, sampled with cpu_req
- cpu_y_in  input  7  new CPU top-left y, sampled with cpu_req
- x  output  8  pixel x to VGA adapter
- y  output  7  pixel y to VGA adapter
- colour  output  3  pixel colour to VGA adapter
- plot  output  1  write enable to VGA adapter; one pixel per high cycle
- busy  output  1  high whenever state != IDLE
- player_done  output  1  one-cycle pulse when a player move completes
- cpu_done  output  1  one-cycle pulse when a CPU move completes

Behaviour:
- All outputs registered. While resetn = 1:
  - x=0, y=0, colour=0, plot=0, player_done=0, cpu_done=0
  - pending flags cleared; old positions loaded with the *_X0/*_Y0 parameters
  - last_served = CPU; state = INIT_P
  - busy = 1 during reset, since the state is not IDLE.
- Reset mid-sequence aborts the sequence immediately. No further pixels are issued from the aborted sequence.
- Request capture:
  - A req pulse sets that channel's pending flag and latches its x/y.
  - A second req on the same channel while still pending overwrites the latched x/y; only the latest position is drawn.
  - A req arriving in the same cycle its channel is granted is captured as a new pending request.
- States:
  - INIT_P: draw player at start position, no erase. Then INIT_C.
  - INIT_C: draw CPU at start position, no erase. Then IDLE.
  - IDLE: if any flag is pending, grant and go to ERASE.
  - ERASE: SPRITE_W*SPRITE_H cycles at the granted channel's old position, colour = BG_COLOUR.
  - DRAW: SPRITE_W*SPRITE_H cycles at the latched new position, colour = channel colour.
  - DONE: 1 cycle. Old position <= new position; pulse the channel's done; clear its pending flag unless re-requested; return to IDLE.
- Arbitration:
  - If only one channel is pending, that channel wins.
  - If both are pending, the channel not equal to last_served wins.
  - last_served updates on grant.
- Pixel order and timing:
  - Row-major from the top-left corner; dx increments fastest.
  - Pixel k has x = base_x + (k mod SPRITE_W) and y = base_y + (k div SPRITE_W), both 8/7-bit modulo.
  - Every ERASE, DRAW and INIT cycle issues exactly one pixel slot.
  - ERASE and DRAW slots are contiguous with no gap.
  - A slot whose pixel has x >= SCREEN_W or y >= SCREEN_H still drives x/y/colour but holds plot = 0.
- Latency: req sampled at edge N gives the first erase pixel on the outputs after edge N+2; DONE follows 2*W*H cycles later.
- Minimum request-to-request period per channel: 2*W*H + 3 cycles. With defaults this is 35.

Test Plan:
- Reset release: 16 plot pulses at (10..13, 40..43), colour 3'b100, then 16 at (10..13, 80..83), colour 3'b001; busy falls after 32 pixel cycles -> plot count 32, no erase.
- player_req with (20, 40): 16 pixels colour 0 at (10..13, 40..43), then 16 colour 3'b100 at (20..23, 40..43) -> player_done pulses once, 35 cycles after req.
- player_req and cpu_req in the same cycle, last_served = CPU: player sequence served first, then CPU -> cpu_done pulses exactly 34 cycles after player_done.
- cpu_req with (158, 118): draw slots at x=160,161 or y=120,121 issue plot = 0 -> exactly 4 draw pixels plotted.
- Two player_reqs while busy with (30, 40) then (31, 40): only (31..34, 40..43) drawn on the next sequence -> one player_done.
- Assert resetn mid-DRAW: plot = 0 the following cycle, pending flags cleared, INIT sequence restarts at start positions.
